// File: rtl/apb_pkg.sv
// Shared APB definitions: slave FSM states and PWRITE encodings.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } slave_state_e;

  localparam logic APB_WRITE = 1'b1;
  localparam logic APB_READ  = 1'b0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separate occupancy register; the head entry is
// always presented on head.
module sync_fifo #(
  parameter int m     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [m-1:0]               push_data,
  input  logic                       pop,
  output logic [m-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [m-1:0]  mem_q [DEPTH];
  logic [m-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == {CW{1'b0}});
  assign count     = count_q;
  assign head      = mem_q[rd_ptr_q];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Next storage, pointer and occupancy values.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; storage is cleared so o_data reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {m{1'b0}};
      end
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/apb_fifo_slave.sv
// APB slave: writes are queued into a FIFO after WAIT_CYCLES wait states,
// reads return the even parity of the FIFO head, and the FIFO drains over valid/ready.
module apb_fifo_slave #(
  parameter int m           = 8,
  parameter int DEPTH       = 4,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [m-1:0]               PWDATA,
  output logic                       PREADY,
  output logic                       PRDATA,
  output logic [m-1:0]               o_data,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  import apb_pkg::*;

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  slave_state_e   state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic           pwrite_q, pwrite_d;
  logic [m-1:0]   pwdata_q, pwdata_d;
  logic           push_s;
  logic           pop_s;
  logic           pready_s;
  logic           prdata_s;
  logic           is_wr_s;
  logic           is_rd_s;
  logic [m-1:0]   head_s;
  logic [OCC_W-1:0] count_s;
  logic           full_s;
  logic           empty_s;

  function automatic logic even_parity(input logic [m-1:0] v);
    return ^v;
  endfunction

  assign is_wr_s = (pwrite_q == APB_WRITE);
  assign is_rd_s = (pwrite_q == APB_READ);
  assign pop_s   = ~empty_s & i_ready;

  // APB next-state, wait counter, latched transfer and PREADY/PRDATA decode.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    push_s   = 1'b0;
    pready_s = 1'b1;
    prdata_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          wcnt_d   = CNT_W'(WAIT_CYCLES);
          pwrite_d = PWRITE;
          pwdata_d = PWDATA;
          state_d  = (WAIT_CYCLES > 0) ? WAIT : READY;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        pready_s = 1'b0;
        if (!PSEL) begin
          state_d = IDLE;
        end else if (PENABLE) begin
          if (wcnt_q <= CNT_W'(1)) begin
            wcnt_d  = {CNT_W{1'b0}};
            state_d = READY;
          end else begin
            wcnt_d  = wcnt_q - 1'b1;
            state_d = WAIT;
          end
        end else begin
          state_d = WAIT;
        end
      end
      READY: begin
        // Write stall uses registered occupancy only: a pop this cycle frees the slot next cycle.
        if (is_rd_s) begin
          pready_s = 1'b1;
          prdata_s = empty_s ? 1'b0 : even_parity(head_s);
        end else begin
          pready_s = ~full_s;
          prdata_s = 1'b0;
        end
        if (!PSEL) begin
          state_d = IDLE;
        end else if (PENABLE && pready_s) begin
          push_s  = is_wr_s;
          state_d = IDLE;
        end else begin
          state_d = READY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // APB state, wait counter and latched setup-phase fields.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q  <= IDLE;
      wcnt_q   <= {CNT_W{1'b0}};
      pwrite_q <= 1'b0;
      pwdata_q <= {m{1'b0}};
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
    end
  end

  sync_fifo #(
    .m     (m),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (PCLK),
    .rst       (PRESET),
    .push      (push_s),
    .push_data (pwdata_q),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign PREADY  = pready_s;
  assign PRDATA  = prdata_s;
  assign o_data  = head_s;
  assign o_valid = ~empty_s;
  assign o_count = count_s;
  assign o_full  = full_s;
  assign o_empty = empty_s;

endmodule

// File: tb/tb_apb_fifo_slave.sv
// Directed bench: instance A uses one wait state, instance B is zero-wait.
module tb_apb_fifo_slave;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PWDATA;
  logic       psel_a, psel_b;
  logic       rdy_a, rdy_b;

  logic       pready_a, prdata_a, valid_a, full_a, empty_a;
  logic [7:0] data_a;
  logic [2:0] count_a;
  logic       pready_b, prdata_b, valid_b, full_b, empty_b;
  logic [7:0] data_b;
  logic [2:0] count_b;

  int vectors     = 0;
  int miscompares = 0;

  int         w;
  logic       d;
  logic       r;
  logic [7:0] exp_q[$];

  always #5 PCLK = ~PCLK;

  apb_fifo_slave #(.m(8), .DEPTH(4), .WAIT_CYCLES(1)) u_a (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_a), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(pready_a), .PRDATA(prdata_a),
    .o_data(data_a), .o_valid(valid_a), .i_ready(rdy_a), .o_count(count_a),
    .o_full(full_a), .o_empty(empty_a)
  );

  apb_fifo_slave #(.m(8), .DEPTH(4), .WAIT_CYCLES(0)) u_b (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel_b), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PREADY(pready_b), .PRDATA(prdata_b),
    .o_data(data_b), .o_valid(valid_b), .i_ready(rdy_b), .o_count(count_b),
    .o_full(full_b), .o_empty(empty_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Full transfer with a bounded wait; optionally pops the drain port on the completing edge.
  task automatic xfer(input logic on_b, input logic wr, input logic [7:0] dat,
                      input logic pop_at_done, output int waits, output logic done,
                      output logic rd_bit);
    waits  = 0;
    done   = 1'b0;
    rd_bit = 1'b0;
    if (on_b) psel_b = 1'b1; else psel_a = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PWDATA  = dat;
    tick();
    PENABLE = 1'b1;
    for (int k = 0; k < 20; k++) begin
      logic pr;
      pr = on_b ? pready_b : pready_a;
      if (pr) begin
        rd_bit = on_b ? prdata_b : prdata_a;
        if (pop_at_done) begin
          if (on_b) rdy_b = 1'b1; else rdy_a = 1'b1;
        end
        tick();
        rdy_a = 1'b0;
        rdy_b = 1'b0;
        done  = 1'b1;
        break;
      end
      waits++;
      tick();
    end
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    PENABLE = 1'b0;
  endtask

  initial begin
    PRESET = 1'b1; psel_a = 1'b0; psel_b = 1'b0; PENABLE = 1'b0;
    PWRITE = 1'b0; PWDATA = 8'h00; rdy_a = 1'b0; rdy_b = 1'b0;
    tick(); tick();
    PRESET = 1'b0;
    #1;
    chk("rst_pready", pready_a, 1);
    chk("rst_prdata", prdata_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_empty", empty_a, 1);
    chk("rst_full", full_a, 0);
    chk("rst_count", count_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_pready_b", pready_b, 1);

    // Reset lands in the middle of a write's wait phase.
    psel_a = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PWDATA = 8'hA5;
    tick();
    PENABLE = 1'b1;
    chk("midwait_pready", pready_a, 0);
    PRESET = 1'b1;
    tick(); tick();
    PRESET = 1'b0; psel_a = 1'b0; PENABLE = 1'b0;
    #1;
    chk("midrst_pready", pready_a, 1);
    chk("midrst_count", count_a, 0);
    chk("midrst_valid", valid_a, 0);
    tick(); tick();
    chk("midrst_nopush_count", count_a, 0);
    chk("midrst_nopush_valid", valid_a, 0);

    xfer(1'b0, 1'b1, 8'h3C, 1'b0, w, d, r);
    chk("w1_done", d, 1);
    chk("w1_waits", w, 1);
    chk("w1_data", data_a, 8'h3C);
    chk("w1_valid", valid_a, 1);
    chk("w1_count", count_a, 1);

    rdy_a = 1'b1; tick(); rdy_a = 1'b0;
    chk("pop1_count", count_a, 0);
    chk("pop1_empty", empty_a, 1);

    for (int i = 1; i <= 4; i++) begin
      xfer(1'b0, 1'b1, 8'(i), 1'b0, w, d, r);
      chk("fill_done", d, 1);
    end
    chk("fill_full", full_a, 1);
    chk("fill_count", count_a, 4);
    chk("fill_head", data_a, 8'h01);

    // Fifth write stalls until one drain pop frees a slot.
    psel_a = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PWDATA = 8'h05;
    tick();
    PENABLE = 1'b1;
    tick();
    chk("stall_pready0", pready_a, 0);
    tick();
    chk("stall_pready1", pready_a, 0);
    chk("stall_count", count_a, 4);
    rdy_a = 1'b1; tick(); rdy_a = 1'b0;
    chk("stall_pop_pready", pready_a, 1);
    chk("stall_pop_count", count_a, 3);
    tick();
    psel_a = 1'b0; PENABLE = 1'b0;
    chk("w5_data", data_a, 8'h02);
    chk("w5_count", count_a, 4);
    chk("w5_full", full_a, 1);

    rdy_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_order", data_a, 8'h02 + 8'(i));
      tick();
    end
    rdy_a = 1'b0;
    chk("drain_empty", empty_a, 1);

    xfer(1'b0, 1'b0, 8'h00, 1'b0, w, d, r);
    chk("rd_empty_done", d, 1);
    chk("rd_empty_prdata", r, 0);
    chk("rd_empty_count", count_a, 0);

    xfer(1'b0, 1'b1, 8'h07, 1'b0, w, d, r);
    xfer(1'b0, 1'b0, 8'h00, 1'b0, w, d, r);
    chk("rd07_done", d, 1);
    chk("rd07_prdata", r, 1);
    chk("rd07_count", count_a, 1);
    rdy_a = 1'b1; tick(); rdy_a = 1'b0;
    xfer(1'b0, 1'b1, 8'h03, 1'b0, w, d, r);
    xfer(1'b0, 1'b0, 8'h00, 1'b0, w, d, r);
    chk("rd03_prdata", r, 0);
    chk("rd03_count", count_a, 1);

    xfer(1'b0, 1'b1, 8'h10, 1'b0, w, d, r);
    chk("pp_pre_count", count_a, 2);
    exp_q = {8'h03, 8'h10};
    for (int i = 0; i < 8; i++) begin
      xfer(1'b0, 1'b1, 8'h20 + 8'(i), 1'b1, w, d, r);
      exp_q.push_back(8'h20 + 8'(i));
      void'(exp_q.pop_front());
      chk("pp_done", d, 1);
      chk("pp_count", count_a, 2);
      chk("pp_head", data_a, exp_q[0]);
    end

    // PSEL withdrawn during the wait phase.
    psel_a = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PWDATA = 8'h99;
    tick();
    chk("abort_wait_pready", pready_a, 0);
    psel_a = 1'b0; PENABLE = 1'b1;
    tick();
    PENABLE = 1'b0;
    chk("abort_idle_pready", pready_a, 1);
    tick(); tick();
    chk("abort_count", count_a, 2);
    chk("abort_head", data_a, exp_q[0]);
    xfer(1'b0, 1'b1, 8'h77, 1'b1, w, d, r);
    exp_q.push_back(8'h77);
    void'(exp_q.pop_front());
    chk("post_abort_waits", w, 1);
    chk("post_abort_head", data_a, exp_q[0]);
    chk("post_abort_count", count_a, 2);

    // Access phase with no preceding setup.
    psel_a = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PWDATA = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("nosetup_pready", pready_a, 1);
    end
    psel_a = 1'b0; PENABLE = 1'b0;
    tick();
    chk("nosetup_count", count_a, 2);
    chk("nosetup_head", data_a, exp_q[0]);

    xfer(1'b1, 1'b1, 8'h5A, 1'b0, w, d, r);
    chk("b_w_done", d, 1);
    chk("b_w_waits", w, 0);
    chk("b_data", data_b, 8'h5A);
    chk("b_valid", valid_b, 1);
    chk("b_count", count_b, 1);
    xfer(1'b1, 1'b0, 8'h00, 1'b0, w, d, r);
    chk("b_rd_waits", w, 0);
    chk("b_rd_prdata", r, 0);
    chk("a_untouched_count", count_a, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
